// File: rtl/led_color_sequencer.sv
// ---------------------------------------------------------------------------
// led_color_sequencer
//
// Purpose:
//   Steps a packed colour code once per programmable interval and drives
//   NUM_LEDS red/blue LED pairs from 2-bit fields of that code. The sequence
//   can be started, paused, cleared, single-stepped and run up or down. A
//   one-cycle wrap pulse marks the edge on which the colour rolls over.
//
// Ports:
//   clk      in   1         system clock
//   rst      in   1         asynchronous reset, active-high
//   start    in   1         enter RUN from IDLE, or resume RUN from PAUSE
//   stop     in   1         RUN -> PAUSE
//   clear    in   1         any state -> IDLE, colour forced to 0
//   step     in   1         single advance from IDLE/PAUSE (lands in PAUSE)
//   dir      in   1         0 = count up, 1 = count down
//   color    out  CW        current colour code (CW = 2*NUM_LEDS)
//   red      out  NUM_LEDS  red[i]  = color[2i],   one cycle behind color
//   blue     out  NUM_LEDS  blue[i] = color[2i+1], one cycle behind color
//   running  out  1         high while the sequencer is in RUN
//   wrap     out  1         one-cycle pulse on the edge the colour wraps
// ---------------------------------------------------------------------------
module led_color_sequencer #(
    parameter longint CLK_HZ   = 125_000_000,
    parameter longint STEP_MS  = 60_000,
    parameter int     NUM_LEDS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stop,
    input  logic                clear,
    input  logic                step,
    input  logic                dir,
    output logic [2*NUM_LEDS-1:0] color,
    output logic [NUM_LEDS-1:0] red,
    output logic [NUM_LEDS-1:0] blue,
    output logic                running,
    output logic                wrap
);

    localparam int     CW    = 2 * NUM_LEDS;
    // 64-bit product: the default clock and interval overflow 32 bits.
    localparam longint TICKS = (CLK_HZ / 1000) * STEP_MS;
    localparam int     PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t          state;
    logic [PW-1:0]   prescaler;
    logic [CW-1:0]   next_color;
    logic            wrap_hit;

    // The colour one advance away, and whether that advance rolls over.
    // Both follow dir as sampled on the advancing edge.
    assign next_color = dir ? (color - CW'(1)) : (color + CW'(1));
    assign wrap_hit   = dir ? (color == '0) : (color == {CW{1'b1}});

    // Single state machine: clear beats stop beats start beats step. The
    // prescaler only moves in RUN, so a pause keeps the phase of the interval
    // and resuming finishes the interval that was in progress. A stop or
    // clear on the terminal tick wins over the advance. The LED outputs
    // decode the registered colour, so they trail it by one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            prescaler <= '0;
            color     <= '0;
            red       <= '0;
            blue      <= '0;
            running   <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            wrap <= 1'b0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                red[i]  <= color[2*i];
                blue[i] <= color[2*i+1];
            end

            if (clear) begin
                state     <= IDLE;
                running   <= 1'b0;
                prescaler <= '0;
                color     <= '0;
            end else begin
                case (state)
                    RUN: begin
                        if (stop) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (prescaler == LAST_TICK) begin
                            prescaler <= '0;
                            color     <= next_color;
                            wrap      <= wrap_hit;
                        end else begin
                            prescaler <= prescaler + PW'(1);
                        end
                    end
                    default: begin
                        // IDLE and PAUSE: a stop here simply holds everything.
                        if (!stop) begin
                            if (start) begin
                                state   <= RUN;
                                running <= 1'b1;
                            end else if (step) begin
                                state <= PAUSE;
                                color <= next_color;
                                wrap  <= wrap_hit;
                            end
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_color_sequencer.sv
// ---------------------------------------------------------------------------
// tb_led_color_sequencer
//
// Purpose:
//   Self-checking bench for led_color_sequencer with TICKS=4 and two LEDs.
//   A behavioural model of the sequencer (mode, interval phase, colour as an
//   integer mod 16) is advanced on every clock edge alongside the design and
//   all outputs are compared one time unit after each edge. Directed steps
//   cover start latency, wrap, down-stepping, pause/resume phase, tick-edge
//   stop+clear and asynchronous reset; a random phase follows.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_led_color_sequencer;

    localparam int NUM_LEDS = 2;
    localparam int CW       = 4;
    localparam int TICKS    = 4;
    localparam int MODULUS  = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic                start = 1'b0;
    logic                stop = 1'b0;
    logic                clear = 1'b0;
    logic                step = 1'b0;
    logic                dir = 1'b0;
    logic [CW-1:0]       color;
    logic [NUM_LEDS-1:0] red;
    logic [NUM_LEDS-1:0] blue;
    logic                running;
    logic                wrap;

    int tests_run  = 0;
    int fail_count = 0;

    // Model: mode 0 = idle, 1 = run, 2 = paused.
    int m_mode    = 0;
    int m_phase   = 0;
    int m_color   = 0;
    int m_wrap    = 0;
    int m_running = 0;
    int m_red     = 0;
    int m_blue    = 0;

    led_color_sequencer #(
        .CLK_HZ(1000),
        .STEP_MS(4),
        .NUM_LEDS(NUM_LEDS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .clear(clear),
        .step(step),
        .dir(dir),
        .color(color),
        .red(red),
        .blue(blue),
        .running(running),
        .wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input int observed, input int expected);
        tests_run++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_color = 0;
        m_wrap = 0; m_running = 0; m_red = 0; m_blue = 0;
    endtask

    // One colour move in the model, arithmetic modulo 16.
    task automatic model_advance(input logic d);
        if (d) begin
            m_wrap  = (m_color == 0) ? 1 : 0;
            m_color = (m_color + MODULUS - 1) % MODULUS;
        end else begin
            m_wrap  = (m_color == MODULUS - 1) ? 1 : 0;
            m_color = (m_color + 1) % MODULUS;
        end
    endtask

    // What one clock edge does to the model, from the sampled controls.
    task automatic model_edge();
        int old_color;
        old_color = m_color;
        m_wrap    = 0;
        if (clear) begin
            m_mode = 0; m_phase = 0; m_color = 0;
        end else if (m_mode == 1) begin
            if (stop) m_mode = 2;
            else if (m_phase == TICKS - 1) begin
                m_phase = 0;
                model_advance(dir);
            end else m_phase++;
        end else if (!stop) begin
            if (start) m_mode = 1;
            else if (step) begin
                m_mode = 2;
                model_advance(dir);
            end
        end
        m_running = (m_mode == 1) ? 1 : 0;
        m_red = 0; m_blue = 0;
        for (int i = 0; i < NUM_LEDS; i++) begin
            m_red  += ((old_color >> (2*i)) & 1) << i;
            m_blue += ((old_color >> (2*i + 1)) & 1) << i;
        end
    endtask

    task automatic compare_all(input string tag);
        check_output({tag, ".color"},   int'(color),   m_color);
        check_output({tag, ".red"},     int'(red),     m_red);
        check_output({tag, ".blue"},    int'(blue),    m_blue);
        check_output({tag, ".running"}, int'(running), m_running);
        check_output({tag, ".wrap"},    int'(wrap),    m_wrap);
    endtask

    // Drive controls at the falling edge, let one rising edge happen, then
    // step the model and compare one time unit later.
    task automatic apply_stimulus(input logic s_start, input logic s_stop,
                                  input logic s_clear, input logic s_step,
                                  input logic s_dir, input string tag);
        @(negedge clk);
        start = s_start; stop = s_stop; clear = s_clear; step = s_step; dir = s_dir;
        @(posedge clk);
        model_edge();
        #1;
        compare_all(tag);
    endtask

    initial begin : stimulus
        int c0;
        int k;

        // Reset state.
        rst = 1'b1;
        model_reset();
        @(posedge clk); #1;
        check_output("reset.color", int'(color), 0);
        check_output("reset.leds", int'({red, blue}), 0);
        check_output("reset.running", int'(running), 0);
        check_output("reset.wrap", int'(wrap), 0);
        @(negedge clk); rst = 1'b0;

        // Start at E0: first advance at E4, second at E8, red[0] at E5.
        apply_stimulus(1, 0, 0, 0, 0, "start.e0");
        check_output("start.running_e0", int'(running), 1);
        for (int i = 1; i <= 3; i++) apply_stimulus(0, 0, 0, 0, 0, "start.wait");
        check_output("start.e3_color", int'(color), 0);
        apply_stimulus(0, 0, 0, 0, 0, "start.e4");
        check_output("start.e4_color", int'(color), 1);
        apply_stimulus(0, 0, 0, 0, 0, "start.e5");
        check_output("start.e5_red", int'(red), 1);
        for (int i = 6; i <= 8; i++) apply_stimulus(0, 0, 0, 0, 0, "start.run");
        check_output("start.e8_color", int'(color), 2);

        // Keep running up through 14, 15 and the wrap to 0.
        k = 0;
        while (!(m_wrap == 1) && k < 80) begin
            apply_stimulus(0, 0, 0, 0, 0, "wrap.run");
            k++;
        end
        check_output("wrap.reached", m_wrap, 1);
        check_output("wrap.color_zero", int'(color), 0);
        apply_stimulus(0, 0, 0, 0, 0, "wrap.after");
        check_output("wrap.one_cycle", int'(wrap), 0);
        check_output("wrap.leds_off", int'({red, blue}), 0);

        // Clear, then step downward from 0: 15 with wrap, then 14 without.
        apply_stimulus(0, 0, 1, 0, 0, "clear");
        apply_stimulus(0, 0, 0, 1, 1, "down.step1");
        check_output("down.step1_color", int'(color), 15);
        check_output("down.step1_wrap", int'(wrap), 1);
        check_output("down.step1_running", int'(running), 0);
        apply_stimulus(0, 0, 0, 1, 1, "down.step2");
        check_output("down.step2_color", int'(color), 14);
        check_output("down.step2_wrap", int'(wrap), 0);

        // Resume from pause, stop with the interval at phase 2, hold, resume.
        apply_stimulus(1, 0, 0, 0, 0, "pause.start");
        k = 0;
        while (m_phase != 2 && k < 10) begin
            apply_stimulus(0, 0, 0, 0, 0, "pause.run");
            k++;
        end
        check_output("pause.phase_reached", m_phase, 2);
        apply_stimulus(0, 1, 0, 0, 0, "pause.stop");
        c0 = m_color;
        for (int i = 0; i < 10; i++) apply_stimulus(0, 0, 0, 0, 0, "pause.hold");
        check_output("pause.frozen", int'(color), c0);
        apply_stimulus(1, 0, 0, 0, 0, "pause.resume");
        apply_stimulus(0, 0, 0, 0, 0, "pause.r1");
        check_output("pause.r1_color", int'(color), c0);
        apply_stimulus(0, 0, 0, 0, 0, "pause.r2");
        check_output("pause.r2_color", int'(color), (c0 + 1) % MODULUS);

        // Stop and clear together on a tick edge.
        k = 0;
        while (m_phase != TICKS - 1 && k < 10) begin
            apply_stimulus(0, 0, 0, 0, 0, "tick.run");
            k++;
        end
        check_output("tick.phase_reached", m_phase, TICKS - 1);
        apply_stimulus(0, 1, 1, 0, 0, "tick.stop_clear");
        check_output("tick.color", int'(color), 0);
        check_output("tick.wrap", int'(wrap), 0);
        check_output("tick.running", int'(running), 0);

        // Step while running is ignored.
        apply_stimulus(1, 0, 0, 0, 0, "runstep.start");
        for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, 1, 0, "runstep.step");

        // Asynchronous reset at phase 1 with colour 9.
        apply_stimulus(0, 0, 1, 0, 0, "ar.clear");
        for (int i = 0; i < 9; i++) apply_stimulus(0, 0, 0, 1, 0, "ar.step");
        check_output("ar.color9", int'(color), 9);
        apply_stimulus(1, 0, 0, 0, 0, "ar.start");
        apply_stimulus(0, 0, 0, 0, 0, "ar.phase1");
        check_output("ar.phase_is_1", m_phase, 1);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_output("ar.color", int'(color), 0);
        check_output("ar.leds", int'({red, blue}), 0);
        check_output("ar.running", int'(running), 0);
        check_output("ar.wrap", int'(wrap), 0);
        @(negedge clk); rst = 1'b0;
        for (int i = 0; i < 6; i++) apply_stimulus(0, 0, 0, 0, 0, "ar.idle");

        // Random control traffic against the model.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 7) == 0),
                           ($urandom_range(0, 11) == 0),
                           ($urandom_range(0, 23) == 0),
                           ($urandom_range(0, 3) == 0),
                           1'($urandom_range(0, 1)),
                           "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, fail_count);
        $finish;
    end

endmodule
